// File: rtl/switch_event_pkg.sv
// Shared constants for the switch event unit: register word addresses and
// the encoding of the bus handshake state machine.
package switch_event_pkg;

  localparam logic [1:0] SEU_ADDR_STATE   = 2'd0;
  localparam logic [1:0] SEU_ADDR_PENDING = 2'd1;
  localparam logic [1:0] SEU_ADDR_RISE_EN = 2'd2;
  localparam logic [1:0] SEU_ADDR_FALL_EN = 2'd3;

  typedef enum logic [1:0] {
    SEU_IDLE = 2'd0,
    SEU_ACK  = 2'd1,
    SEU_WAIT = 2'd2
  } seu_state_t;

endpackage

// File: rtl/switch_edge_detect.sv
// Per-bit rising/falling edge detector for the debounced switch vector.
// Keeps the previous sample; the enables only qualify the outgoing events.
module switch_edge_detect #(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] i_switch,
  input  logic [WIDTH-1:0] i_rise_en,
  input  logic [WIDTH-1:0] i_fall_en,
  output logic [WIDTH-1:0] o_rise,
  output logic [WIDTH-1:0] o_fall
);

  logic [WIDTH-1:0] r_prev;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_prev <= '0;
    end else begin
      r_prev <= i_switch;
    end
  end

  assign o_rise = i_switch & ~r_prev & i_rise_en;
  assign o_fall = ~i_switch & r_prev & i_fall_en;

endmodule

// File: rtl/switch_event_unit.sv
// Memory-mapped switch event controller: sticky W1C pending bits from
// enabled switch edges, a level interrupt, and a Read/Write/Ack bus slave.
module switch_event_unit
  import switch_event_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] switch_in,
  input  logic [1:0]       Address,
  input  logic [31:0]      DataIn,
  input  logic             Read,
  input  logic             Write,
  output logic [31:0]      DataOut,
  output logic             Ack,
  output logic             Interrupt
);

  seu_state_t       r_state;
  seu_state_t       w_state_next;
  logic [WIDTH-1:0] r_pending;
  logic [WIDTH-1:0] r_rise_en;
  logic [WIDTH-1:0] r_fall_en;
  logic             r_interrupt;
  logic [31:0]      r_dataout;
  logic [WIDTH-1:0] w_rise;
  logic [WIDTH-1:0] w_fall;
  logic [WIDTH-1:0] w_clear;
  logic [WIDTH-1:0] w_pending_next;
  logic [31:0]      w_rdata;
  logic             w_wr;
  logic             w_rd;
  logic             w_unused;

  switch_edge_detect #(.WIDTH(WIDTH)) u_edge (
    .clock     (clock),
    .reset     (reset),
    .i_switch  (switch_in),
    .i_rise_en (r_rise_en),
    .i_fall_en (r_fall_en),
    .o_rise    (w_rise),
    .o_fall    (w_fall)
  );

  // Requests are only accepted in IDLE; write wins when both are raised.
  assign w_wr = (r_state == SEU_IDLE) && Write;
  assign w_rd = (r_state == SEU_IDLE) && Read && !Write;

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      SEU_IDLE: if (Write || Read) w_state_next = SEU_ACK;
      SEU_ACK:  w_state_next = SEU_WAIT;
      SEU_WAIT: if (!Read && !Write) w_state_next = SEU_IDLE;
      default:  w_state_next = SEU_IDLE;
    endcase
  end

  always_comb begin
    w_clear = '0;
    if (w_wr && (Address == SEU_ADDR_PENDING)) w_clear = DataIn[WIDTH-1:0];
  end

  // New events are OR-ed in after the clear so a same-cycle event survives.
  assign w_pending_next = (r_pending & ~w_clear) | w_rise | w_fall;

  always_comb begin
    w_rdata = '0;
    case (Address)
      SEU_ADDR_STATE:   w_rdata[WIDTH-1:0] = switch_in;
      SEU_ADDR_PENDING: w_rdata[WIDTH-1:0] = r_pending;
      SEU_ADDR_RISE_EN: w_rdata[WIDTH-1:0] = r_rise_en;
      default:          w_rdata[WIDTH-1:0] = r_fall_en;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state     <= SEU_IDLE;
      r_pending   <= '0;
      r_rise_en   <= '0;
      r_fall_en   <= '0;
      r_interrupt <= 1'b0;
      r_dataout   <= '0;
    end else begin
      r_state     <= w_state_next;
      r_pending   <= w_pending_next;
      r_interrupt <= |w_pending_next;
      // Read data lives only for the ACK cycle and is zero otherwise.
      r_dataout   <= w_rd ? w_rdata : '0;
      if (w_wr && (Address == SEU_ADDR_RISE_EN)) r_rise_en <= DataIn[WIDTH-1:0];
      if (w_wr && (Address == SEU_ADDR_FALL_EN)) r_fall_en <= DataIn[WIDTH-1:0];
    end
  end

  assign Ack       = (r_state == SEU_ACK);
  assign DataOut   = r_dataout;
  assign Interrupt = r_interrupt;

  // Upper data bits are ignored when WIDTH < 32.
  assign w_unused = ^DataIn;

endmodule

// File: tb/tb_switch_event_unit.sv
// Directed self-checking bench for switch_event_unit: register access,
// edge capture, W1C behaviour, handshake rules and mid-transaction reset.
module tb_switch_event_unit;

  logic        clock;
  logic        reset;
  logic [7:0]  switch_in;
  logic [1:0]  Address;
  logic [31:0] DataIn;
  logic        Read;
  logic        Write;
  logic [31:0] DataOut;
  logic        Ack;
  logic        Interrupt;

  int checks;
  int errors;

  switch_event_unit #(.WIDTH(8)) dut (
    .clock     (clock),
    .reset     (reset),
    .switch_in (switch_in),
    .Address   (Address),
    .DataIn    (DataIn),
    .Read      (Read),
    .Write     (Write),
    .DataOut   (DataOut),
    .Ack       (Ack),
    .Interrupt (Interrupt)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Called 1ns after a posedge; returns 1ns after a posedge with the FSM back in IDLE.
  task automatic xfer(input logic wr, input logic rd, input logic [1:0] addr,
                      input logic [31:0] wdata, output logic [31:0] rdata, output int acks);
    rdata   = '0;
    acks    = 0;
    Address = addr;
    DataIn  = wdata;
    Write   = wr;
    Read    = rd;
    for (int i = 0; i < 20 && acks == 0; i++) begin
      @(posedge clock); #1;
      if (Ack) begin
        acks++;
        rdata = DataOut;
      end
    end
    Write = 1'b0;
    Read  = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clock); #1;
      if (Ack) acks++;
    end
    $display("xfer wr=%0b rd=%0b addr=%0d wdata=%h rdata=%h acks=%0d", wr, rd, addr, wdata, rdata, acks);
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clock); #1;
    end
  endtask

  task automatic test_reset();
    logic [31:0] rd;
    int ac;
    reset = 1'b0; switch_in = 8'h00; Address = 2'd0; DataIn = '0; Read = 1'b0; Write = 1'b0;
    tick(3);
    checks++;
    if ({Ack, Interrupt, DataOut} !== 34'd0) begin
      errors++;
      $display("FAIL reset_outputs: got ack=%b irq=%b data=%h, want 0 0 0", Ack, Interrupt, DataOut);
    end
    reset = 1'b1;
    tick(1);
    for (int a = 0; a < 4; a++) begin
      xfer(1'b0, 1'b1, a[1:0], 32'h0, rd, ac);
      checks++;
      if (ac !== 1 || rd !== 32'h0) begin
        errors++;
        $display("FAIL reset_read_%0d: got acks=%0d data=%h, want 1 00000000", a, ac, rd);
      end
    end
    switch_in = 8'h5A;
    xfer(1'b0, 1'b1, 2'd0, 32'h0, rd, ac);
    checks++;
    if (rd !== 32'h0000_005A) begin
      errors++;
      $display("FAIL state_read: got %h, want 0000005a", rd);
    end
    switch_in = 8'h00;
    tick(2);
  endtask

  task automatic test_rise();
    logic [31:0] rd;
    int ac;
    xfer(1'b1, 1'b0, 2'd2, 32'h0000_0005, rd, ac);
    switch_in = 8'h07;
    checks++;
    if (Interrupt !== 1'b0) begin
      errors++;
      $display("FAIL rise_irq_before: got %b, want 0", Interrupt);
    end
    tick(1);
    checks++;
    if (Interrupt !== 1'b1) begin
      errors++;
      $display("FAIL rise_irq_after: got %b, want 1", Interrupt);
    end
    xfer(1'b0, 1'b1, 2'd1, 32'h0, rd, ac);
    checks++;
    if (rd !== 32'h0000_0005) begin
      errors++;
      $display("FAIL rise_pending: got %h, want 00000005", rd);
    end
  endtask

  task automatic test_fall_w1c();
    logic [31:0] rd;
    int ac;
    xfer(1'b1, 1'b0, 2'd3, 32'h0000_0080, rd, ac);
    switch_in = 8'h87;
    tick(2);
    switch_in = 8'h07;
    tick(2);
    xfer(1'b0, 1'b1, 2'd1, 32'h0, rd, ac);
    checks++;
    if (rd !== 32'h0000_0085) begin
      errors++;
      $display("FAIL fall_pending: got %h, want 00000085", rd);
    end
    xfer(1'b1, 1'b0, 2'd1, 32'h0000_0080, rd, ac);
    xfer(1'b0, 1'b1, 2'd1, 32'h0, rd, ac);
    checks++;
    if (rd !== 32'h0000_0005 || Interrupt !== 1'b1) begin
      errors++;
      $display("FAIL w1c_bit7: got pending=%h irq=%b, want 00000005 1", rd, Interrupt);
    end
    xfer(1'b1, 1'b0, 2'd1, 32'h0000_0005, rd, ac);
    checks++;
    if (Interrupt !== 1'b0) begin
      errors++;
      $display("FAIL w1c_irq_low: got %b, want 0", Interrupt);
    end
  endtask

  task automatic test_w1c_race();
    logic [31:0] rd;
    int ac;
    switch_in = 8'h06; tick(1);
    switch_in = 8'h07; tick(1);
    switch_in = 8'h06; tick(1);
    Address = 2'd1; DataIn = 32'h0000_0001; Write = 1'b1; switch_in = 8'h07;
    tick(1);
    checks++;
    if (Ack !== 1'b1) begin
      errors++;
      $display("FAIL race_ack: got %b, want 1", Ack);
    end
    Write = 1'b0;
    tick(3);
    xfer(1'b0, 1'b1, 2'd1, 32'h0, rd, ac);
    checks++;
    if (rd !== 32'h0000_0001 || Interrupt !== 1'b1) begin
      errors++;
      $display("FAIL race_pending: got pending=%h irq=%b, want 00000001 1", rd, Interrupt);
    end
    xfer(1'b1, 1'b0, 2'd1, 32'h0000_0001, rd, ac);
    xfer(1'b0, 1'b1, 2'd1, 32'h0, rd, ac);
    checks++;
    if (rd !== 32'h0) begin
      errors++;
      $display("FAIL race_cleanup: got %h, want 00000000", rd);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd;
    int ac;
    ac = 0;
    Address = 2'd2; Read = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clock); #1;
      if (Ack) ac++;
    end
    Read = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clock); #1;
      if (Ack) ac++;
    end
    $display("xfer held_read addr=2 acks=%0d", ac);
    checks++;
    if (ac !== 1) begin
      errors++;
      $display("FAIL held_read_acks: got %0d, want 1", ac);
    end
    xfer(1'b1, 1'b1, 2'd2, 32'h0000_000F, rd, ac);
    checks++;
    if (ac !== 1 || rd !== 32'h0) begin
      errors++;
      $display("FAIL rw_both: got acks=%0d data=%h, want 1 00000000", ac, rd);
    end
    xfer(1'b0, 1'b1, 2'd2, 32'h0, rd, ac);
    checks++;
    if (rd !== 32'h0000_000F) begin
      errors++;
      $display("FAIL rw_both_readback: got %h, want 0000000f", rd);
    end
  endtask

  task automatic test_reset_in_wait();
    logic [31:0] rd;
    int ac;
    xfer(1'b1, 1'b0, 2'd2, 32'h0000_00FF, rd, ac);
    switch_in = 8'h00; tick(2);
    switch_in = 8'hFF; tick(2);
    xfer(1'b0, 1'b1, 2'd1, 32'h0, rd, ac);
    checks++;
    if (rd !== 32'h0000_00FF || Interrupt !== 1'b1) begin
      errors++;
      $display("FAIL all_pending: got pending=%h irq=%b, want 000000ff 1", rd, Interrupt);
    end
    ac = 0;
    Address = 2'd1; Read = 1'b1;
    for (int i = 0; i < 20 && ac == 0; i++) begin
      @(posedge clock); #1;
      if (Ack) ac++;
    end
    tick(2);
    checks++;
    if (ac !== 1 || Ack !== 1'b0) begin
      errors++;
      $display("FAIL wait_state: got acks=%0d ack=%b, want 1 0", ac, Ack);
    end
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({Ack, Interrupt, DataOut} !== 34'd0) begin
      errors++;
      $display("FAIL reset_in_wait: got ack=%b irq=%b data=%h, want 0 0 0", Ack, Interrupt, DataOut);
    end
    Read = 1'b0;
    tick(2);
    reset = 1'b1;
    tick(1);
    xfer(1'b0, 1'b1, 2'd1, 32'h0, rd, ac);
    checks++;
    if (ac !== 1 || rd !== 32'h0) begin
      errors++;
      $display("FAIL post_reset_pending: got acks=%0d data=%h, want 1 00000000", ac, rd);
    end
    xfer(1'b0, 1'b1, 2'd2, 32'h0, rd, ac);
    checks++;
    if (rd !== 32'h0) begin
      errors++;
      $display("FAIL post_reset_rise_en: got %h, want 00000000", rd);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_rise();
    test_fall_w1c();
    test_w1c_race();
    test_back_to_back();
    test_reset_in_wait();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
